// File: rtl/beam_pkg.sv
// beam_pkg: shared types and default constants for the break-beam emitter.
//   state_e     - emitter FSM states
//   CLK_HZ      - system clock frequency
//   CARRIER_HZ  - IR carrier frequency
//   HALF_PERIOD - clk cycles per carrier half-period, derived from the two above
package beam_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StGap   = 2'd2
    } state_e;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned CARRIER_HZ  = 38_000;
    localparam int unsigned HALF_PERIOD = CLK_HZ / (2 * CARRIER_HZ);

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: square-wave carrier and period timer for the IR emitter.
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   run_i         - run level for the coming cycle; a rising edge restarts the phase
//   carrier_o     - carrier level for the coming cycle (steady 1 when MODULATE = 0)
//   period_tick_o - high on the last cycle of each full carrier period
module ir_carrier_gen #(
    parameter int unsigned HALF_PERIOD = 1315,
    parameter bit          MODULATE    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic carrier_o,
    output logic period_tick_o
);

    localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carrier_q, carrier_d;
    logic             running_q, running_d;

    // run_i describes the next cycle, so the _d values are what the next cycle sees;
    // the owner can register carrier_o straight into its LED flop.
    always_comb begin
        cnt_d     = cnt_q;
        carrier_d = carrier_q;
        running_d = running_q;
        if (!run_i) begin
            cnt_d     = '0;
            carrier_d = 1'b0;
            running_d = 1'b0;
        end else if (!running_q) begin
            cnt_d     = '0;
            carrier_d = 1'b1;
            running_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            carrier_d = ~carrier_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            carrier_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            carrier_q <= carrier_d;
            running_q <= running_d;
        end
    end

    assign carrier_o     = MODULATE ? carrier_d : 1'b1;
    // Low half ends the period.
    assign period_tick_o = running_q && !carrier_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/beam_emitter.sv
// beam_emitter: IR LED driver for the basketball break-beam sensor. Emits bursts
// separated by gaps, checks the receiver at the end of each burst, and raises a
// sticky fault after FAULT_BURSTS consecutive unseen bursts.
// Build option: define BEAM_EMITTER_CARRIER_EN to modulate ir_led with the carrier;
// otherwise ir_led is steady high for the whole burst.
//   clk          - system clock, 100 MHz
//   rst_n        - asynchronous active-low reset
//   enable       - run request, level
//   beam_in      - raw receiver output, asynchronous (1 = beam present)
//   fault_clr    - one-cycle pulse clearing beam_fault and the miss count
//   ir_led       - registered LED drive
//   burst_active - high for every BURST cycle
//   beam_ok      - result of the most recent burst check
//   beam_fault   - sticky fault flag
module beam_emitter #(
    parameter int unsigned HALF_PERIOD   = beam_pkg::HALF_PERIOD,
    parameter int unsigned BURST_PERIODS = 16,
    parameter int unsigned GAP_PERIODS   = 16,
    parameter int unsigned FAULT_BURSTS  = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic beam_in,
    input  logic fault_clr,
    output logic ir_led,
    output logic burst_active,
    output logic beam_ok,
    output logic beam_fault
);

    import beam_pkg::*;

`ifdef BEAM_EMITTER_CARRIER_EN
    localparam bit CARRIER_EN = 1'b1;
`else
    localparam bit CARRIER_EN = 1'b0;
`endif

    localparam int unsigned PER_MAX = (BURST_PERIODS > GAP_PERIODS) ? BURST_PERIODS
                                                                    : GAP_PERIODS;
    localparam int unsigned PER_W   = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;
    localparam int unsigned MISS_W  = $clog2(FAULT_BURSTS + 1);

    localparam logic [PER_W-1:0]  BURST_LAST = PER_W'(BURST_PERIODS - 1);
    localparam logic [PER_W-1:0]  GAP_LAST   = PER_W'(GAP_PERIODS - 1);
    localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(FAULT_BURSTS);
    localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(FAULT_BURSTS - 1);

    state_e              state_q, state_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic                sync1_q, sync2_q;
    logic                ir_led_q, ir_led_d;
    logic                burst_active_q, burst_active_d;
    logic                beam_ok_q, beam_ok_d;
    logic                beam_fault_q, beam_fault_d;
    logic                check;
    logic                carrier;
    logic                period_tick;

    ir_carrier_gen #(
        .HALF_PERIOD (HALF_PERIOD),
        .MODULATE    (CARRIER_EN)
    ) u_carrier (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (state_d != StIdle),
        .carrier_o     (carrier),
        .period_tick_o (period_tick)
    );

    // Sequencing: count whole carrier periods in BURST and GAP.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        check     = 1'b0;
        if (!enable) begin
            state_d   = StIdle;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d   = StBurst;
                    per_cnt_d = '0;
                end
                StBurst: begin
                    if (period_tick) begin
                        if (per_cnt_q == BURST_LAST) begin
                            state_d   = StGap;
                            per_cnt_d = '0;
                            check     = 1'b1;
                        end else begin
                            per_cnt_d = per_cnt_q + 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (period_tick) begin
                        if (per_cnt_q == GAP_LAST) begin
                            state_d   = StBurst;
                            per_cnt_d = '0;
                        end else begin
                            per_cnt_d = per_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = StIdle;
                    per_cnt_d = '0;
                end
            endcase
        end
    end

    // Beam check and fault tracking; a fault set beats a coincident clear.
    always_comb begin
        beam_ok_d    = beam_ok_q;
        miss_cnt_d   = miss_cnt_q;
        beam_fault_d = beam_fault_q;
        if (fault_clr) begin
            miss_cnt_d   = '0;
            beam_fault_d = 1'b0;
        end
        if (check) begin
            if (sync2_q) begin
                beam_ok_d  = 1'b1;
                miss_cnt_d = '0;
            end else begin
                beam_ok_d = 1'b0;
                if (miss_cnt_q == MISS_LAST) begin
                    miss_cnt_d   = MISS_MAX;
                    beam_fault_d = 1'b1;
                end else if (miss_cnt_q != MISS_MAX && !fault_clr) begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end
        end
    end

    assign ir_led_d       = (state_d == StBurst) && carrier;
    assign burst_active_d = (state_d == StBurst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            per_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            ir_led_q       <= 1'b0;
            burst_active_q <= 1'b0;
            beam_ok_q      <= 1'b0;
            beam_fault_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            per_cnt_q      <= per_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            sync1_q        <= beam_in;
            sync2_q        <= sync1_q;
            ir_led_q       <= ir_led_d;
            burst_active_q <= burst_active_d;
            beam_ok_q      <= beam_ok_d;
            beam_fault_q   <= beam_fault_d;
        end
    end

    assign ir_led       = ir_led_q;
    assign burst_active = burst_active_q;
    assign beam_ok      = beam_ok_q;
    assign beam_fault   = beam_fault_q;

endmodule

// File: doc/beam_emitter.md
Name: beam_emitter

Overview:
- Drives the IR LED of the basketball break-beam sensor. It is the transmit end of the link whose receive end produces the FABINT score pulse.
- Emits carrier-modulated bursts separated by gaps.
- Samples the receiver level at the end of each burst. This proves the beam path is aligned.
- Raises a sticky fault to the processor when too many consecutive bursts go unseen, for example a misaligned or dead emitter.

Parameters:
- HALF_PERIOD, 1315: clk cycles per carrier half-period (100 MHz / 76 kHz, floor). Must be >= 1.
- BURST_PERIODS, 16: carrier periods per burst.
- GAP_PERIODS, 16: carrier periods of LED-off gap after each burst.
- FAULT_BURSTS, 64: consecutive unseen bursts that set beam_fault. Must be >= 1.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  emitter run request, level
- beam_in  in  1  raw receiver output; 1 = beam present. Asynchronous to clk.
- fault_clr  in  1  one-cycle pulse; clears beam_fault and the miss count
- ir_led  out  1  LED drive, registered
- burst_active  out  1  high for every cycle the FSM is in BURST
- beam_ok  out  1  result of the most recent burst check
- beam_fault  out  1  sticky fault flag

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - ir_led, burst_active, beam_ok and beam_fault all = 0.
  - FSM = IDLE.
  - All counters = 0; synchronizer flops = 0.
- beam_in passes through a 2-flop synchronizer, giving 2 cycles of latency. Only the synchronized value is used.
- FSM states: IDLE, BURST, GAP.
  - IDLE -> BURST on the clock where enable = 1.
  - BURST lasts exactly 2*HALF_PERIOD*BURST_PERIODS cycles, then -> GAP.
  - GAP lasts exactly 2*HALF_PERIOD*GAP_PERIODS cycles, then -> BURST.
  - enable = 0 in any state -> IDLE on the next clock. ir_led = 0 from that cycle on. The burst in progress is abandoned and not checked.
  - beam_ok and the miss count hold their values while in IDLE.
- Carrier during BURST:
  - ir_led = 1 on the first BURST cycle and toggles every HALF_PERIOD cycles.
  - The half-period counter restarts at 0 on every BURST entry.
  - ir_led = 0 throughout GAP and IDLE.
- burst_active is a registered copy of (state == BURST) and is coincident with the ir_led envelope.
- Check on the last BURST cycle (sampled value = synchronized beam_in):
  - Sample 1: beam_ok <= 1, miss_cnt <= 0.
  - Sample 0: beam_ok <= 0, miss_cnt <= miss_cnt + 1, saturating at FAULT_BURSTS.
  - Each check result is visible on the cycle after the last BURST cycle.
- beam_fault <= 1 when miss_cnt transitions to FAULT_BURSTS. It stays set until fault_clr.
- fault_clr:
  - Sets beam_fault to 0 and miss_cnt to 0 next cycle.
  - If it coincides with a failing check that would set the fault, the set wins: beam_fault = 1, miss_cnt = FAULT_BURSTS.
  - If it coincides with any other check, the clear wins for miss_cnt.
- Counter widths: $clog2(max count + 1). No wrap is possible; every counter is reset at its terminal value.
- Reset mid-burst: ir_led drops immediately (asynchronous) and the FSM returns to IDLE.

Optional Feature:
- Macro: BEAM_EMITTER_CARRIER_EN.
- Defined: ir_led carries the modulated carrier, as described in Behaviour.
- Undefined:
  - ir_led = 1 steady for the whole BURST, for unmodulated photodiode receivers.
  - HALF_PERIOD still sets burst and gap durations.
  - All other behaviour is identical.

Decomposition:
- Package beam_pkg:
  - State enum (IDLE, BURST, GAP).
  - Default constants CLK_HZ = 100_000_000, CARRIER_HZ = 38_000 and the derived HALF_PERIOD.
- One sub-module, ir_carrier_gen:
  - Inputs: run (restart on rise) and HALF_PERIOD.
  - Outputs: carrier level and a period_tick pulse.
  - beam_emitter counts period_tick to time BURST and GAP.

Test Plan (HALF_PERIOD=4, BURST_PERIODS=2, GAP_PERIODS=2, FAULT_BURSTS=3, so burst = 16 cycles and gap = 16 cycles):
- Reset, then enable=1 held, beam_in=1:
  - ir_led pattern 1111 0000 1111 0000, then 16 zeros, then repeats.
  - burst_active high for exactly 16 cycles per 32.
  - beam_ok = 1 after the first burst.
- beam_in=0 for 3 bursts -> beam_ok = 0 after the first burst; beam_fault = 1 on the cycle after the 3rd burst ends. beam_in back to 1 -> beam_ok = 1, beam_fault stays 1. fault_clr pulse -> beam_fault = 0 next cycle.
- fault_clr on the same cycle as the 3rd failing check -> beam_fault = 1 (set wins).
- enable dropped at BURST cycle 6 -> ir_led = 0 the next cycle, FSM in IDLE, no check performed, miss_cnt unchanged.
- rst_n asserted mid-GAP with beam_fault = 1 -> all outputs 0 immediately, without waiting for a clock edge.
- Build with BEAM_EMITTER_CARRIER_EN undefined -> ir_led = 1 for all 16 BURST cycles, timing otherwise identical.
